// File: rtl/accum_pkg.sv
// accum_pkg: shared types for the partial-sum accumulator array.
//   state_t   - controller state (IDLE / ACCUM / DRAIN)
//   sat_add   - signed saturating add, present only when ACCUM_SAT_EN is defined
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

`ifdef ACCUM_SAT_EN
    typedef struct packed {
        logic        ovf;
        logic [63:0] val;
    } sat_res_t;

    // a and b are already sign-extended to 64 bits; w is the real accumulator
    // width. The 65-bit sum cannot itself overflow, so clamping against the
    // w-bit signed range is exact.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned w);
        logic signed [64:0] s, hi, lo;
        sat_res_t r;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        r.ovf = 1'b0;
        r.val = s[63:0];
        if (s > hi) begin
            r.ovf = 1'b1;
            r.val = hi[63:0];
        end else if (s < lo) begin
            r.ovf = 1'b1;
            r.val = lo[63:0];
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/accum_lane.sv
// accum_lane: one column's DEPTH-entry partial-sum store.
//   wr_en/wr_first/wr_data : write strobe (already qualified by ACCUM), overwrite vs add, signed input
//   rd_mode                : high while the array is in DRAIN; low holds rp/rd_cnt at 0
//   out_ready/out_valid/out_data : drain handshake, out_data = mem[rp]
//   wp_zero  : write pointer has wrapped back to 0 (pass boundary)
//   rd_last  : lane is finished draining, or finishes on this cycle's handshake
//   ovf      : sticky saturation flag (constant 0 unless ACCUM_SAT_EN)
module accum_lane #(
    parameter int DEPTH = 8,
    parameter int IN_W  = 24,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic             wr_first,
    input  logic [IN_W-1:0]  wr_data,
    input  logic             rd_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             wp_zero,
    output logic             rd_last,
    output logic             ovf
);
`ifdef ACCUM_SAT_EN
    import accum_pkg::*;
`endif

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ACC_W-1:0]        mem [DEPTH];
    logic [PW-1:0]           wp, rp;
    logic [CW-1:0]           rd_cnt;
    logic signed [ACC_W-1:0] ext, sum;
    logic                    sum_ovf;
    logic                    hs;

    assign ext = ACC_W'($signed(wr_data));

    always_comb begin
        sum     = mem[wp] + ext;
        sum_ovf = 1'b0;
`ifdef ACCUM_SAT_EN
        begin
            sat_res_t sr;
            sr      = sat_add(64'($signed(mem[wp])), 64'(ext), ACC_W);
            sum     = sr.val[ACC_W-1:0];
            sum_ovf = sr.ovf;
        end
`endif
    end

    assign out_valid = rd_mode && (rd_cnt < CW'(DEPTH));
    assign out_data  = mem[rp];
    assign hs        = out_valid && out_ready;
    assign wp_zero   = (wp == '0);
    assign rd_last   = rd_mode && ((rd_cnt == CW'(DEPTH)) ||
                                   (hs && (rd_cnt == CW'(DEPTH - 1))));

    // DEPTH is a power of two, so wp/rp wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp     <= '0;
            rp     <= '0;
            rd_cnt <= '0;
            ovf    <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp     <= '0;
            rp     <= '0;
            rd_cnt <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_first ? ext : sum;
                wp      <= wp + PW'(1);
                if (!wr_first && sum_ovf) ovf <= 1'b1;
            end
            // Read side only advances inside DRAIN; outside it the pointers
            // are parked at 0 so the next drain starts at entry 0.
            if (!rd_mode) begin
                rp     <= '0;
                rd_cnt <= '0;
            end else if (hs) begin
                mem[rp] <= '0;
                rp      <= rp + PW'(1);
                rd_cnt  <= rd_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/accumulator_array.sv
// accumulator_array: N-lane partial-sum accumulator behind the systolic array.
// Ports: clk, rst_n (async low), clear (sync, top priority), start, drain,
//   in_first/in_valid/in_data/in_ready (write side, ACCUM only),
//   out_valid/out_ready/out_data (per-lane drain), done (pulse on DRAIN->IDLE),
//   err (sticky rejected drain), ovf (sticky per-lane saturation).
// Build option: define ACCUM_SAT_EN for saturating adds with ovf reporting;
//   otherwise adds wrap and ovf stays 0.
module accumulator_array
    import accum_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int DEPTH     = 8,
    parameter int IN_W      = 24,
    parameter int ACC_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       drain,
    input  logic                       in_first,
    input  logic [NUM_LANES-1:0]       in_valid,
    input  logic [NUM_LANES*IN_W-1:0]  in_data,
    output logic                       in_ready,
    output logic [NUM_LANES-1:0]       out_valid,
    input  logic [NUM_LANES-1:0]       out_ready,
    output logic [NUM_LANES*ACC_W-1:0] out_data,
    output logic                       done,
    output logic                       err,
    output logic [NUM_LANES-1:0]       ovf
);

    state_t               state;
    logic [NUM_LANES-1:0] wp_zero, rd_last;
    logic                 accum_st, drain_st;

    assign accum_st = (state == ACCUM);
    assign drain_st = (state == DRAIN);
    assign in_ready = accum_st;

    for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
        accum_lane #(
            .DEPTH (DEPTH),
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .wr_en     (accum_st && in_valid[c]),
            .wr_first  (in_first),
            .wr_data   (in_data[c*IN_W +: IN_W]),
            .rd_mode   (drain_st),
            .out_ready (out_ready[c]),
            .out_valid (out_valid[c]),
            .out_data  (out_data[c*ACC_W +: ACC_W]),
            .wp_zero   (wp_zero[c]),
            .rd_last   (rd_last[c]),
            .ovf       (ovf[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:  if (start) state <= ACCUM;
                // A drain is only legal on a pass boundary, i.e. once every
                // lane's write pointer has wrapped back to entry 0.
                ACCUM: if (drain) begin
                    if (&wp_zero) state <= DRAIN;
                    else          err   <= 1'b1;
                end
                DRAIN: if (&rd_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
